dmem_port_arbiter: RTL

- Arbitrates the single data-memory port between the pipeline Memory stage (CPU side) and a DMA/loader requester.
- Sits between the Memory stage's load/store controls (MemRead/MemWrite, ALU-result address, write data) and the synchronous data RAM.
- CPU has priority. A starvation counter forces a DMA slot after a bounded wait; the CPU is stalled for that cycle.
- Tracks read ownership so returning RAM data is steered to the right requester.

---
 rtl/dmem_port_arbiter_if.sv | 46 ++++
 rtl/dmem_port_arbiter.sv | 122 ++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle for dmem_port_arbiter: CPU Memory-stage port, DMA/loader port and RAM port.
// The slave modport is the arbiter's view; master is the surrounding requesters and RAM.
interface dmem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_rd;
  logic              cpu_wr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_stall;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_rd, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: CPU priority, starvation-forced DMA slot, 1-cycle read steering.
// Optional performance counters enabled by defining ARB_PERF_CNT_EN.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input logic                clk,
  input logic                reset,
  dmem_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]        perf_cpu_stall_cnt,
  output logic [31:0]        perf_dma_gnt_cnt
`endif
);

  localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

  typedef enum logic [1:0] {OwnNone, OwnCpu, OwnDma} owner_e;

  owner_e     rd_owner_q, rd_owner_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;

  logic              cpu_req;
  logic              dma_win;
  logic              cpu_issue;
  logic              stall_int;
  logic              sel_en;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  assign cpu_req   = bus.cpu_rd | bus.cpu_wr;
  assign dma_win   = bus.dma_req & (~cpu_req | (starve_cnt_q == StarveMax));
  assign cpu_issue = cpu_req & ~dma_win;
  assign stall_int = cpu_req & dma_win;

  // RAM drive: the winner owns address, data and write enable; idle drives zeros.
  always_comb begin
    sel_en    = 1'b0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    if (dma_win) begin
      sel_en    = 1'b1;
      sel_we    = bus.dma_we;
      sel_addr  = bus.dma_addr;
      sel_wdata = bus.dma_wdata;
    end else if (cpu_req) begin
      sel_en    = 1'b1;
      sel_we    = bus.cpu_wr;
      sel_addr  = bus.cpu_addr;
      sel_wdata = bus.cpu_wdata;
    end
  end

  always_comb begin
    rd_owner_d = OwnNone;
    if (dma_win && !bus.dma_we) begin
      rd_owner_d = OwnDma;
    end else if (cpu_issue && bus.cpu_rd && !bus.cpu_wr) begin
      rd_owner_d = OwnCpu;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.dma_req || dma_win) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q != StarveMax) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_owner_q   <= OwnNone;
      starve_cnt_q <= 4'd0;
    end else begin
      rd_owner_q   <= rd_owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Everything is held at zero while reset is high, including data returning from a read
  // issued just before reset.
  assign bus.mem_en     = ~reset & sel_en;
  assign bus.mem_we     = ~reset & sel_we;
  assign bus.mem_addr   = reset ? '0 : sel_addr;
  assign bus.mem_wdata  = reset ? '0 : sel_wdata;
  assign bus.dma_gnt    = ~reset & dma_win;
  assign bus.cpu_stall  = ~reset & stall_int;
  assign bus.cpu_rvalid = ~reset & (rd_owner_q == OwnCpu);
  assign bus.dma_rvalid = ~reset & (rd_owner_q == OwnDma);
  assign bus.cpu_rdata  = (!reset && rd_owner_q == OwnCpu) ? bus.mem_rdata : '0;
  assign bus.dma_rdata  = (!reset && rd_owner_q == OwnDma) ? bus.mem_rdata : '0;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_gnt_q, perf_gnt_d;

  always_comb begin
    perf_stall_d = perf_stall_q + {31'd0, stall_int};
    perf_gnt_d   = perf_gnt_q + {31'd0, dma_win};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_q <= 32'd0;
      perf_gnt_q   <= 32'd0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_gnt_q   <= perf_gnt_d;
    end
  end

  assign perf_cpu_stall_cnt = reset ? 32'd0 : perf_stall_q;
  assign perf_dma_gnt_cnt   = reset ? 32'd0 : perf_gnt_q;
`endif

endmodule
